// File: rtl/spgd_pkg.sv
// Shared SPGD definitions: controller state encoding and fixed-point word defaults.
package spgd_pkg;

  localparam int FP_WIDTH_DEF  = 32;
  localparam int INT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } adc_state_e;

endpackage

// File: rtl/spgd_adc_capture.sv
// ADC capture for the SPGD loop: settle after a request, average 2^AVG_LOG2 strobed
// samples, present the result in fixed point under a 4-phase EN/DONE handshake.
module spgd_adc_capture
  import spgd_pkg::*;
#(
  parameter int FP_WIDTH   = FP_WIDTH_DEF,
  parameter int INT_WIDTH  = INT_WIDTH_DEF,
  parameter int ADC_BITS   = 14,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_CYC = 16
) (
  input  logic                ADC_CLK,
  input  logic                RST_N,
  input  logic                ADC_EN,
  input  logic [ADC_BITS-1:0] ADC_RAW,
  input  logic                ADC_RAW_VLD,
  output logic [FP_WIDTH-1:0] ADC_DATA,
  output logic                ADC_DONE,
  output logic                BUSY,
  output logic                OVR
);

  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int SHIFT = FP_WIDTH - INT_WIDTH - ADC_BITS;

  localparam logic [SMP_W-1:0] LAST_SMP    = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  if (ADC_BITS > FP_WIDTH - INT_WIDTH) begin : g_bits_check
    $error("spgd_adc_capture: ADC_BITS must not exceed FP_WIDTH-INT_WIDTH");
  end
  if (SETTLE_CYC < 1) begin : g_settle_check
    $error("spgd_adc_capture: SETTLE_CYC must be at least 1");
  end

  adc_state_e          state_r, state_nxt_s;
  logic [SET_W-1:0]    settle_cnt_r;
  logic [SMP_W-1:0]    smp_cnt_r;
  logic [ACC_W-1:0]    acc_r;
  logic                batch_ovr_r;
  logic [FP_WIDTH-1:0] data_r;
  logic                ovr_r;
  logic                done_r;
  logic                busy_r;

  logic                start_s;
  logic                accept_s;
  logic                commit_s;
  logic [ACC_W-1:0]    sum_s;
  logic [ADC_BITS-1:0] avg_s;
  logic                raw_full_s;

  // Sum includes the strobe in flight so the final sample is part of the committed result.
  assign sum_s      = acc_r + ACC_W'(ADC_RAW);
  assign avg_s      = sum_s[ACC_W-1:AVG_LOG2];
  assign raw_full_s = &ADC_RAW;

  // State register.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a dropped request always wins over a strobe in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ADC_EN) begin
          start_s     = 1'b1;
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!ADC_EN) begin
          state_nxt_s = ST_IDLE;
        end else if (settle_cnt_r == '0) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_ACCUM: begin
        if (!ADC_EN) begin
          state_nxt_s = ST_IDLE;
        end else if (ADC_RAW_VLD) begin
          accept_s = 1'b1;
          if (smp_cnt_r == LAST_SMP) begin
            commit_s    = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (!ADC_EN) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Settle counter, accumulator and per-batch full-scale flag.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle_cnt_r <= '0;
      smp_cnt_r    <= '0;
      acc_r        <= '0;
      batch_ovr_r  <= 1'b0;
    end else if (start_s) begin
      settle_cnt_r <= SETTLE_LOAD;
      smp_cnt_r    <= '0;
      acc_r        <= '0;
      batch_ovr_r  <= 1'b0;
    end else begin
      if (state_r == ST_SETTLE && settle_cnt_r != '0) begin
        settle_cnt_r <= settle_cnt_r - SET_W'(1);
      end
      if (accept_s) begin
        acc_r       <= sum_s;
        smp_cnt_r   <= smp_cnt_r + SMP_W'(1);
        batch_ovr_r <= batch_ovr_r | raw_full_s;
      end
    end
  end

  // Result registers: touched only when a full batch completes, so aborts leave them intact.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_r <= '0;
      ovr_r  <= 1'b0;
    end else if (commit_s) begin
      data_r <= FP_WIDTH'(avg_s) << SHIFT;
      ovr_r  <= batch_ovr_r | raw_full_s;
    end
  end

  // Status flags registered from the next state so they line up with the state register.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == ST_DONE);
      busy_r <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_ACCUM);
    end
  end

  assign ADC_DATA = data_r;
  assign ADC_DONE = done_r;
  assign BUSY     = busy_r;
  assign OVR      = ovr_r;

endmodule
